store_merge_unit: RTL

STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

---
 rtl/mips_defs_pkg.sv | 37 +++
 rtl/store_merge_unit_if.sv | 29 ++
 rtl/store_lane_merge.sv | 25 ++
 rtl/store_merge_unit.sv | 104 ++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS datapath definitions: store-type encodings, store FSM state
// encodings and the little-endian byte-lane mapping shared by store merge and load split.
package mips_defs_pkg;

  typedef logic [1:0] store_type_t;

  localparam store_type_t ST_SW = 2'b00;
  localparam store_type_t ST_SH = 2'b01;
  localparam store_type_t ST_SB = 2'b10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  // Byte lanes touched by an access; the reserved encoding behaves as a full word.
  function automatic logic [3:0] lane_mask(input store_type_t st, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (st)
      ST_SB:   m = 4'b0001 << addr_lo;
      ST_SH:   m = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_align(input store_type_t st, input logic [31:0] data);
    logic [31:0] a;
    case (st)
      ST_SB:   a = {4{data[7:0]}};
      ST_SH:   a = {2{data[15:0]}};
      default: a = data;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/store_merge_unit_if.sv
// Pipeline-side and memory-side signals of the store merge unit; the unit
// itself uses the slave modport, the environment driving it uses master.
interface store_merge_unit_if #(parameter int ADDR_W = 32);
  import mips_defs_pkg::*;

  logic              ex_mem_mem_write;
  store_type_t       ex_mem_store_type;
  logic [ADDR_W-1:0] ex_mem_addr;
  logic [31:0]       ex_mem_store_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;
  logic              stall;
  logic              store_done;
  logic              misalign_exc;

  modport slave (
    input  ex_mem_mem_write, ex_mem_store_type, ex_mem_addr, ex_mem_store_data, mem_rdata,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata, stall, store_done, misalign_exc
  );

  modport master (
    output ex_mem_mem_write, ex_mem_store_type, ex_mem_addr, ex_mem_store_data, mem_rdata,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata, stall, store_done, misalign_exc
  );

endinterface

// File: rtl/store_lane_merge.sv
// Combinational read-modify-write merge: overlays the store lanes of data
// onto the old memory word using the shared lane mapping.
module store_lane_merge
  import mips_defs_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  store_type_t store_type,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  logic [3:0]  mask;
  logic [31:0] aligned;

  always_comb begin
    mask    = lane_mask(store_type, addr_lo);
    aligned = lane_align(store_type, data);
    merged  = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[8*i +: 8] = aligned[8*i +: 8];
    end
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store unit turning SW/SH/SB into word writes (read-modify-write for partial stores).
// Optional misaligned-store trap enabled by defining STORE_MISALIGN_TRAP_EN.
module store_merge_unit
  import mips_defs_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  store_merge_unit_if.slave bus
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       data_q, data_d;
  store_type_t       type_q, type_d;
  logic [1:0]        addr_lo_q, addr_lo_d;

  logic        req;
  logic        is_sw_req;
  logic        misalign;
  logic        accept;
  logic [31:0] merged;

  // Gating with rst_n keeps stall and the trap flag low while reset is held.
  assign req       = (state_q == S_IDLE) & bus.ex_mem_mem_write & rst_n;
  assign is_sw_req = (bus.ex_mem_store_type != ST_SH) && (bus.ex_mem_store_type != ST_SB);

`ifdef STORE_MISALIGN_TRAP_EN
  assign misalign = req & (is_sw_req ? (bus.ex_mem_addr[1:0] != 2'b00)
                                     : ((bus.ex_mem_store_type == ST_SH) & bus.ex_mem_addr[0]));
`else
  assign misalign = 1'b0;
`endif

  assign accept = req & ~misalign;

  store_lane_merge u_merge (
    .old_word  (bus.mem_rdata),
    .data      (data_q),
    .store_type(type_q),
    .addr_lo   (addr_lo_q),
    .merged    (merged)
  );

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    data_d      = data_q;
    type_d      = type_q;
    addr_lo_d   = addr_lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d     = bus.ex_mem_store_data;
          type_d     = bus.ex_mem_store_type;
          addr_lo_d  = bus.ex_mem_addr[1:0];
          mem_addr_d = {bus.ex_mem_addr[ADDR_W-1:2], 2'b00};
          if (is_sw_req) begin
            mem_wdata_d = bus.ex_mem_store_data;
            state_d     = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:    state_d = S_WAIT;
      S_WAIT: begin
        mem_wdata_d = merged;
        state_d     = S_WR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      data_q      <= '0;
      type_q      <= ST_SW;
      addr_lo_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      data_q      <= data_d;
      type_q      <= type_d;
      addr_lo_q   <= addr_lo_d;
    end
  end

  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_rd_en    = (state_q == S_RD);
  assign bus.mem_wr_en    = (state_q == S_WR);
  assign bus.store_done   = (state_q == S_WR);
  assign bus.stall        = accept | (state_q == S_RD) | (state_q == S_WAIT);
  assign bus.misalign_exc = misalign;

endmodule
